// File: rtl/bat_amateur_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bat_amateur_pkg
//  Brief    : Shared types and constants for the BatAmateur bus controller.
//  Revision : 1.0
// ============================================================================
package bat_amateur_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [15:0] OUT_BASE_DEFAULT = 16'hFF00;
    localparam logic        RW_READ          = 1'b1;
    localparam logic        RW_WRITE         = 1'b0;

endpackage
`default_nettype wire

// File: rtl/bat_amateur_ram.sv
`default_nettype none
// ============================================================================
//  Module   : bat_amateur_ram
//  Brief    : Single-port RAM, synchronous write, asynchronous read.
//  Revision : 1.0
// ============================================================================
module bat_amateur_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // No reset: program contents must survive a core/controller reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/bat_amateur_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bat_amateur_bus_ctrl
//  Brief    : BatAmateur memory/IO controller: RAM, loader, output channels,
//             run/halt sequencing and run-cycle counter.
//  Revision : 1.0
// ============================================================================
module bat_amateur_bus_ctrl
    import bat_amateur_pkg::*;
#(
    parameter int                       DATA_WIDTH    = 16,
    parameter int                       ADDRESS_WIDTH = 16,
    parameter int                       RAM_DEPTH     = 256,
    parameter int                       OUT_CHANNELS  = 2,
    parameter logic [ADDRESS_WIDTH-1:0] OUT_BASE      = ADDRESS_WIDTH'(OUT_BASE_DEFAULT),
    parameter int                       COUNT_WIDTH   = 32
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [ADDRESS_WIDTH-1:0]           ADDRESS,
    inout  wire  [DATA_WIDTH-1:0]              DATA,
    input  logic                               RAM_RW,
    input  logic                               RAM_EN,
    input  logic                               HALT,
    output logic                               CORE_RST,
    input  logic                               LOAD_VALID,
    input  logic [ADDRESS_WIDTH-1:0]           LOAD_ADDR,
    input  logic [DATA_WIDTH-1:0]              LOAD_DATA,
    input  logic                               LOAD_DONE,
    output logic                               LOAD_READY,
    output logic [OUT_CHANNELS*DATA_WIDTH-1:0] OUT,
    output logic [OUT_CHANNELS-1:0]            OUT_VALID,
    output logic [COUNT_WIDTH-1:0]             CYCLES,
    output logic                               HALTED,
    output logic                               BUS_ERR
);

    localparam int                     RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH:0] RAM_LIMIT = (ADDRESS_WIDTH+1)'(RAM_DEPTH);

    state_e                  state_q;
    logic                    core_rst_q;
    logic                    load_ready_q;
    logic                    halted_q;
    logic                    bus_err_q;
    logic [COUNT_WIDTH-1:0]  cycles_q;
    logic [DATA_WIDTH-1:0]   out_q [OUT_CHANNELS];
    logic [OUT_CHANNELS-1:0] out_valid_q;

    logic                    w_bus_in_ram;
    logic                    w_load_in_ram;
    logic [OUT_CHANNELS-1:0] w_ch_hit;
    logic                    w_bus_in_out;
    logic                    w_unmapped;
    logic                    w_run_acc;
    logic                    w_bus_rd;
    logic                    w_bus_wr;
    logic                    w_ram_we;
    logic [RAM_AW-1:0]       w_ram_addr;
    logic [DATA_WIDTH-1:0]   w_ram_wdata;
    logic [DATA_WIDTH-1:0]   w_ram_rdata;
    logic [DATA_WIDTH-1:0]   w_rd_data;

    // Extra top bit keeps the compare correct when RAM_DEPTH == 2**ADDRESS_WIDTH.
    assign w_bus_in_ram  = ({1'b0, ADDRESS}   < RAM_LIMIT);
    assign w_load_in_ram = ({1'b0, LOAD_ADDR} < RAM_LIMIT);

    generate
        for (genvar k = 0; k < OUT_CHANNELS; k++) begin : g_channel
            assign w_ch_hit[k]                       = (ADDRESS == OUT_BASE + ADDRESS_WIDTH'(k));
            assign OUT[k*DATA_WIDTH +: DATA_WIDTH]   = out_q[k];
        end
    endgenerate

    assign w_bus_in_out = |w_ch_hit;
    assign w_unmapped   = !w_bus_in_ram && !w_bus_in_out;
    assign w_run_acc    = (state_q == ST_RUN) && RAM_EN;
    assign w_bus_rd     = w_run_acc && (RAM_RW == RW_READ);
    assign w_bus_wr     = w_run_acc && (RAM_RW == RW_WRITE);

    // The loader owns the RAM port while loading; the core owns it afterwards.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_addr  = ADDRESS[RAM_AW-1:0];
        w_ram_wdata = DATA;
        if (state_q == ST_LOAD) begin
            w_ram_we    = LOAD_VALID && w_load_in_ram;
            w_ram_addr  = LOAD_ADDR[RAM_AW-1:0];
            w_ram_wdata = LOAD_DATA;
        end else begin
            w_ram_we    = w_bus_wr && w_bus_in_ram;
        end
    end

    bat_amateur_ram #(
        .DEPTH (RAM_DEPTH),
        .WIDTH (DATA_WIDTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (w_ram_we),
        .addr_i  (w_ram_addr),
        .wdata_i (w_ram_wdata),
        .rdata_o (w_ram_rdata)
    );

    always_comb begin
        w_rd_data = '0;
        if (w_bus_in_ram) begin
            w_rd_data = w_ram_rdata;
        end else begin
            for (int k = 0; k < OUT_CHANNELS; k++) begin
                if (w_ch_hit[k]) begin
                    w_rd_data = out_q[k];
                end
            end
        end
    end

    assign DATA = w_bus_rd ? w_rd_data : {DATA_WIDTH{1'bz}};

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= ST_LOAD;
            core_rst_q   <= 1'b0;
            load_ready_q <= 1'b1;
            halted_q     <= 1'b0;
            bus_err_q    <= 1'b0;
            cycles_q     <= '0;
            out_valid_q  <= '0;
            for (int k = 0; k < OUT_CHANNELS; k++) begin
                out_q[k] <= '0;
            end
        end else begin
            out_valid_q <= '0;
            case (state_q)
                ST_LOAD: begin
                    if (LOAD_DONE) begin
                        state_q      <= ST_RUN;
                        core_rst_q   <= 1'b1;
                        load_ready_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cycles_q != {COUNT_WIDTH{1'b1}}) begin
                        cycles_q <= cycles_q + 1'b1;
                    end
                    if (w_run_acc && w_unmapped) begin
                        bus_err_q <= 1'b1;
                    end
                    if (w_bus_wr) begin
                        for (int k = 0; k < OUT_CHANNELS; k++) begin
                            if (w_ch_hit[k]) begin
                                out_q[k]       <= DATA;
                                out_valid_q[k] <= 1'b1;
                            end
                        end
                    end
                    // A write presented alongside HALT still commits above.
                    if (HALT) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign CORE_RST   = core_rst_q;
    assign LOAD_READY = load_ready_q;
    assign HALTED     = halted_q;
    assign BUS_ERR    = bus_err_q;
    assign CYCLES     = cycles_q;
    assign OUT_VALID  = out_valid_q;

endmodule
`default_nettype wire
